// File: rtl/mix_sched_pkg.sv
// Shared definitions for the TS/EMM/DDR mixer slot scheduler.
package mix_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int GNT_TS  = 0;
    localparam int GNT_DDR = 1;
    localparam int GNT_EMM = 2;

    localparam int GAP_CYC_DEF  = 8;
    localparam int SLOT_TMO_DEF = 64;

endpackage

// File: rtl/emm_token_bucket.sv
// EMM insertion rate limiter: period counter feeding a saturating token bucket.
module emm_token_bucket #(
    parameter int TOK_W   = 3,
    parameter int MAX_TOK = 4,
    parameter int PER_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PER_W-1:0] emm_period,
    input  logic             consume,
    output logic [TOK_W-1:0] tokens,
    output logic             avail
);

    localparam logic [TOK_W-1:0] TOK_MAX = TOK_W'(MAX_TOK);

    logic [PER_W-1:0] cnt;
    logic [PER_W-1:0] per_q;
    logic [TOK_W-1:0] tok;
    logic             unlimited;
    logic             restart;
    logic             add;
    logic             take;

    assign unlimited = (emm_period == '0);
    assign restart   = (emm_period != per_q);
    assign add       = !unlimited && !restart && (cnt == emm_period - PER_W'(1));
    assign take      = !unlimited && consume && (tok != '0);

    // Unlimited mode parks the level at MAX_TOK so the reported level is full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            per_q <= '0;
            tok   <= '0;
        end else begin
            per_q <= emm_period;
            if (unlimited || restart || add)
                cnt <= '0;
            else
                cnt <= cnt + PER_W'(1);

            if (unlimited)
                tok <= TOK_MAX;
            else if (add && !take && tok != TOK_MAX)
                tok <= tok + TOK_W'(1);
            else if (take && !add)
                tok <= tok - TOK_W'(1);
        end
    end

    assign tokens = tok;
    assign avail  = unlimited || (tok != '0);

endmodule

// File: rtl/mix_slot_sched.sv
// Slot scheduler for the TS/EMM/DDR output mixer: priority arbitration,
// EMM rate limiting, DDR anti-starvation, slot timeout and inter-slot gap.
module mix_slot_sched
    import mix_sched_pkg::*;
#(
    parameter int GAP_CYC  = GAP_CYC_DEF,
    parameter int SLOT_TMO = SLOT_TMO_DEF,
    parameter int TOK_W    = 3,
    parameter int MAX_TOK  = 4,
    parameter int PER_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_ts,
    input  logic             req_emm,
    input  logic             req_ddr,
    input  logic             slot_done,
    input  logic [PER_W-1:0] emm_period,
    input  logic [3:0]       ddr_weight,
    output logic [2:0]       gnt,
    output logic             gnt_vld,
    output logic             busy,
    output logic [TOK_W-1:0] emm_tokens,
    output logic             timeout_err
);

    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int TMO_W = $clog2(SLOT_TMO + 1);
    // The IDLE arbitration cycle is the last gnt-low cycle of the gap, so GAP
    // itself lasts GAP_CYC-1 cycles and re-grant lands GAP_CYC+1 after slot_done.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SLOT_TMO - 1);

    state_t           state, state_d;
    logic [2:0]       sel;
    logic             tmo_fire;
    logic             force_ddr;
    logic             emm_avail;
    logic [3:0]       starve_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    emm_token_bucket #(
        .TOK_W   (TOK_W),
        .MAX_TOK (MAX_TOK),
        .PER_W   (PER_W)
    ) u_bucket (
        .clk        (clk),
        .rst        (rst),
        .emm_period (emm_period),
        .consume    (state == ST_IDLE && sel[GNT_EMM]),
        .tokens     (emm_tokens),
        .avail      (emm_avail)
    );

    assign force_ddr = req_ddr && (ddr_weight != 4'd0) && (starve_cnt >= ddr_weight);

    always_comb begin
        state_d  = state;
        sel      = '0;
        tmo_fire = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (force_ddr)               sel[GNT_DDR] = 1'b1;
                else if (req_ts)             sel[GNT_TS]  = 1'b1;
                else if (req_emm && emm_avail) sel[GNT_EMM] = 1'b1;
                else if (req_ddr)            sel[GNT_DDR] = 1'b1;
                if (sel != '0) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (slot_done) begin
                    state_d = ST_GAP;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d  = ST_GAP;
                    tmo_fire = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            gnt_vld     <= 1'b0;
            timeout_err <= 1'b0;
            starve_cnt  <= '0;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
        end else begin
            state       <= state_d;
            gnt_vld     <= (state == ST_IDLE) && (sel != '0);
            timeout_err <= tmo_fire;
            if (state == ST_IDLE)
                gnt <= sel;
            else if (state_d != ST_GRANT)
                gnt <= '0;
            tmo_cnt <= (state == ST_GRANT) ? tmo_cnt + TMO_W'(1) : '0;
            gap_cnt <= (state == ST_GAP)   ? gap_cnt + GAP_W'(1) : '0;
            if (state == ST_IDLE) begin
                if (sel[GNT_DDR] || !req_ddr)
                    starve_cnt <= '0;
                else if (sel != '0 && starve_cnt != 4'hF)
                    starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mix_slot_sched.sv
// Scoreboard bench for mix_slot_sched: expected grants queued per scenario.
module tb_mix_slot_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_ts = 1'b0, req_emm = 1'b0, req_ddr = 1'b0, slot_done = 1'b0;
    logic [15:0] emm_period = 16'd0;
    logic [3:0]  ddr_weight = 4'd0;
    logic [2:0]  gnt;
    logic        gnt_vld, busy, timeout_err;
    logic [2:0]  emm_tokens;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [2:0] exp_q[$];
    int         exp_int_q[$];

    localparam logic [2:0] G_TS = 3'b001, G_DDR = 3'b010, G_EMM = 3'b100;

    mix_slot_sched dut (
        .clk         (clk),
        .rst         (rst),
        .req_ts      (req_ts),
        .req_emm     (req_emm),
        .req_ddr     (req_ddr),
        .slot_done   (slot_done),
        .emm_period  (emm_period),
        .ddr_weight  (ddr_weight),
        .gnt         (gnt),
        .gnt_vld     (gnt_vld),
        .busy        (busy),
        .emm_tokens  (emm_tokens),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_vld(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (gnt_vld) ok = 1'b1;
        end
    endtask

    task automatic expect_grant(input string name, input int budget);
        bit ok;
        logic [2:0] e;
        e = exp_q.pop_front();
        wait_vld(budget, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no gnt_vld within %0d cycles, expected gnt %b", name, budget, e);
        end else if (gnt !== e) begin
            errors++;
            $display("FAIL %s: gnt=%b expected %b", name, gnt, e);
        end
    endtask

    task automatic end_slot();
        slot_done = 1'b1;
        @(negedge clk);
        slot_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL %s: busy still %b after 40 cycles, expected 0", name, busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        emm_period = 16'd100;
        repeat (3) @(negedge clk);
        checks += 5;
        if (gnt !== 3'b000)     begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        if (gnt_vld !== 1'b0)   begin errors++; $display("FAIL reset_vld: got %b want 0", gnt_vld); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
        if (emm_tokens !== 3'd0) begin errors++; $display("FAIL reset_tokens: got %0d want 0", emm_tokens); end
        rst = 1'b1;
        emm_period = 16'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ts_gap();
        bit held;
        req_ts = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== G_TS || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL ts_latency: gnt=%b vld=%b want 001/1", gnt, gnt_vld);
        end
        held = 1'b1;
        repeat (52) begin
            @(negedge clk);
            if (gnt !== G_TS || gnt_vld !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!held) begin errors++; $display("FAIL ts_hold: gnt not held at 001 (now %b)", gnt); end
        end_slot();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (gnt !== 3'b000) begin
                errors++;
                $display("FAIL ts_gap%0d: gnt=%b want 000", i, gnt);
            end
        end
        @(negedge clk);
        checks++;
        if (gnt !== G_TS || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL ts_regrant: gnt=%b vld=%b want 001/1", gnt, gnt_vld);
        end
        req_ts = 1'b0;
        end_slot();
        wait_idle("ts_idle");
    endtask

    task automatic test_priority();
        ddr_weight = 4'd0;
        req_ts = 1'b1; req_emm = 1'b1; req_ddr = 1'b1;
        for (int s = 0; s < 4; s++) begin
            exp_q.push_back(G_TS);
            expect_grant($sformatf("prio_slot%0d", s), 20);
            repeat (3) @(negedge clk);
            end_slot();
        end
        req_ts = 1'b0; req_emm = 1'b0; req_ddr = 1'b0;
        wait_idle("prio_idle");
    endtask

    task automatic test_ddr_weight();
        logic [2:0] seq [8];
        seq = '{G_TS, G_TS, G_TS, G_DDR, G_TS, G_TS, G_TS, G_DDR};
        ddr_weight = 4'd3;
        for (int s = 0; s < 8; s++) exp_q.push_back(seq[s]);
        req_ts = 1'b1; req_ddr = 1'b1;
        for (int s = 0; s < 8; s++) begin
            expect_grant($sformatf("weight_slot%0d", s), 20);
            repeat (3) @(negedge clk);
            end_slot();
        end
        req_ts = 1'b0; req_ddr = 1'b0;
        ddr_weight = 4'd0;
        wait_idle("weight_idle");
    endtask

    task automatic test_timeout();
        bit held;
        emm_period = 16'd0;
        req_ts = 1'b1;
        exp_q.push_back(G_TS);
        expect_grant("tmo_grant", 5);
        held = 1'b1;
        repeat (63) begin
            @(negedge clk);
            if (gnt !== G_TS || timeout_err !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!held) begin errors++; $display("FAIL tmo_early: gnt=%b err=%b before 64 cycles", gnt, timeout_err); end
        @(negedge clk);
        req_ts = 1'b0;
        checks++;
        if (timeout_err !== 1'b1 || gnt !== 3'b000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_pulse: err=%b gnt=%b busy=%b want 1/000/1", timeout_err, gnt, busy);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_width: err=%b want 0", timeout_err); end
        wait_idle("tmo_idle");
    endtask

    task automatic test_reset_mid();
        emm_period = 16'd100;
        repeat (2) @(negedge clk);
        checks++;
        if (emm_tokens !== 3'd4) begin errors++; $display("FAIL pre_rst_tokens: got %0d want 4", emm_tokens); end
        req_ddr = 1'b1;
        exp_q.push_back(G_DDR);
        expect_grant("rst_first", 5);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 3;
        if (gnt !== 3'b000)      begin errors++; $display("FAIL rst_mid_gnt: got %b want 000", gnt); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        if (emm_tokens !== 3'd0) begin errors++; $display("FAIL rst_mid_tokens: got %0d want 0", emm_tokens); end
        @(negedge clk);
        req_emm = 1'b1;
        rst = 1'b1;
        exp_q.push_back(G_DDR);
        expect_grant("rst_after", 5);
        req_ddr = 1'b0; req_emm = 1'b0;
        end_slot();
        wait_idle("rst_idle");
    endtask

    task automatic test_emm_rate();
        int t0, t_last, dt;
        @(negedge clk);
        rst = 1'b0;
        emm_period = 16'd100;
        @(negedge clk);
        rst = 1'b1;
        req_emm = 1'b1;
        t0 = cyc;
        exp_q.push_back(G_EMM);
        expect_grant("emm_first", 150);
        dt = cyc - t0;
        checks++;
        if (dt < 95 || dt > 110) begin errors++; $display("FAIL emm_first_time: %0d cycles, want 95..110", dt); end
        t_last = cyc;
        for (int g = 0; g < 3; g++) begin
            repeat (4) @(negedge clk);
            end_slot();
            exp_q.push_back(G_EMM);
            exp_int_q.push_back(100);
            expect_grant($sformatf("emm_grant%0d", g), 150);
            dt = cyc - t_last;
            t_last = cyc;
            checks++;
            if (dt !== exp_int_q.pop_front()) begin
                errors++;
                $display("FAIL emm_interval%0d: %0d cycles, want 100", g, dt);
            end
        end
        req_emm = 1'b0;
        end_slot();
        repeat (1000) @(negedge clk);
        checks++;
        if (emm_tokens !== 3'd4) begin errors++; $display("FAIL emm_saturate: got %0d want 4", emm_tokens); end
    endtask

    initial begin
        test_reset();
        test_ts_gap();
        test_priority();
        test_ddr_weight();
        test_timeout();
        test_reset_mid();
        test_emm_rate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
